// File: rtl/mux2_arbiter_16bit_pkg.sv
// Shared definitions for the mux2_arbiter_16bit block.
// Defines the mux select encodings and the output-buffer FSM state type.
package mux2_arbiter_16bit_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/mux2_16bit.sv
// 16-bit 2:1 data multiplexer.
// Ports: A, B - data inputs; sel - 0 selects A, 1 selects B; X - selected word.
module mux2_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sel,
  output logic [15:0] X
);

  assign X = sel ? B : A;

endmodule

// File: rtl/mux2_arbiter_16bit.sv
// Round-robin arbiter plus one-entry output buffer for the shared 2:1 mux.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   req_a/A/ack_a         - requester A handshake and data
//   req_b/B/ack_b         - requester B handshake and data
//   X/x_valid/x_ready     - buffered output word with valid/ready handshake
//   sel                   - mux select in use (0 = A, 1 = B)
//   xfer_cnt              - captured-word count, wraps at 2^CNT_W
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no undelivered word in X, x_valid = 0
// ST_FULL  | X holds an undelivered word, x_valid = 1
module mux2_arbiter_16bit
  import mux2_arbiter_16bit_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter bit A_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [15:0]      A,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [15:0]      B,
  output logic             ack_b,
  output logic [15:0]      X,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  // last_grant resets to the opposite of the side that should win first
  localparam logic LAST_GRANT_RST = A_FIRST ? SEL_B : SEL_A;

  state_e           state_q, state_d;
  logic [15:0]      x_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic             sel_q;

  logic             any_req;
  logic             grant;
  logic             can_load;
  logic             load;
  logic [15:0]      mux_out;

  assign any_req  = req_a | req_b;
  assign can_load = (state_q == ST_EMPTY) | x_ready;
  // rst_n gates the load so no ack escapes while reset is asserted
  assign load     = can_load & any_req & rst_n;

  always_comb begin
    grant = ~last_grant_q;
    if (req_a && !req_b) begin
      grant = SEL_A;
    end else if (req_b && !req_a) begin
      grant = SEL_B;
    end
  end

  mux2_16bit u_mux (
    .A   (A),
    .B   (B),
    .sel (sel),
    .X   (mux_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (any_req)             state_d = ST_FULL;
      ST_FULL:  if (x_ready && !any_req) state_d = ST_EMPTY;
      default:                           state_d = ST_EMPTY;
    endcase
  end

  // Output logic; sel only follows the grant when a capture actually happens
  always_comb begin
    ack_a   = load & (grant == SEL_A);
    ack_b   = load & (grant == SEL_B);
    x_valid = (state_q == ST_FULL);
    sel     = load ? grant : sel_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      cnt_q        <= '0;
      last_grant_q <= LAST_GRANT_RST;
      sel_q        <= SEL_A;
    end else if (load) begin
      x_q          <= mux_out;
      cnt_q        <= cnt_q + CNT_W'(1);
      last_grant_q <= grant;
      sel_q        <= grant;
    end
  end

  assign X        = x_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_mux2_arbiter_16bit.sv
// Directed self-checking bench for mux2_arbiter_16bit (CNT_W=8, A_FIRST=1).
module tb_mux2_arbiter_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, x_ready;
  logic [15:0] A, B, X;
  logic        ack_a, ack_b, x_valid, sel;
  logic [7:0]  xfer_cnt;

  int vectors     = 0;
  int miscompares = 0;

  mux2_arbiter_16bit #(.CNT_W(8), .A_FIRST(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .A        (A),
    .ack_a    (ack_a),
    .req_b    (req_b),
    .B        (B),
    .ack_b    (ack_b),
    .X        (X),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .sel      (sel),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset with A requesting
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0; A = 16'd40; B = 16'd0; x_ready = 1'b1;
    tick(); tick();
    #1;
    chk("rst_X",       32'(X),        32'd0);
    chk("rst_x_valid", 32'(x_valid),  32'd0);
    chk("rst_ack_a",   32'(ack_a),    32'd0);
    chk("rst_ack_b",   32'(ack_b),    32'd0);
    chk("rst_cnt",     32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_ack_a", 32'(ack_a), 32'd1);
    chk("first_sel",   32'(sel),   32'd0);
    tick();
    chk("first_X",     32'(X),        32'd40);
    chk("first_valid", 32'(x_valid),  32'd1);
    chk("first_cnt",   32'(xfer_cnt), 32'd1);

    // 2. contention from fresh reset: A,B,A,B
    req_a = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1; A = 16'd40; B = 16'd33;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ack_a", 32'(ack_a), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_ack_b", 32'(ack_b), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("cont_sel",   32'(sel),   (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("cont_X",     32'(X),     (i % 2 == 1) ? 32'd33 : 32'd40);
      chk("cont_valid", 32'(x_valid), 32'd1);
    end
    chk("cont_cnt", 32'(xfer_cnt), 32'd4);

    // 3. backpressure
    req_a = 1'b0; req_b = 1'b0;
    tick();
    chk("bp_drain_valid", 32'(x_valid), 32'd0);
    req_a = 1'b1; A = 16'h00AA;
    tick();
    chk("bp_load_X",   32'(X),        32'h00AA);
    chk("bp_load_cnt", 32'(xfer_cnt), 32'd5);
    req_a = 1'b0; req_b = 1'b1; B = 16'h0055; x_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ack_b",  32'(ack_b), 32'd0);
      chk("bp_ack_a",  32'(ack_a), 32'd0);
      chk("bp_sel",    32'(sel),   32'd0);
      tick();
      chk("bp_hold_X", 32'(X),       32'h00AA);
      chk("bp_valid",  32'(x_valid), 32'd1);
    end
    x_ready = 1'b1;
    #1;
    chk("bp_rel_ack_b", 32'(ack_b), 32'd1);
    chk("bp_rel_sel",   32'(sel),   32'd1);
    tick();
    chk("bp_rel_X",   32'(X),        32'h0055);
    chk("bp_rel_cnt", 32'(xfer_cnt), 32'd6);

    // 4. drain: valid for exactly one cycle, x_ready while EMPTY ignored
    req_b = 1'b0;
    chk("drain_valid0", 32'(x_valid), 32'd1);
    tick();
    chk("drain_valid1", 32'(x_valid), 32'd0);
    tick();
    chk("drain_valid2", 32'(x_valid), 32'd0);
    chk("drain_cnt",    32'(xfer_cnt), 32'd6);

    // 5. counter wrap
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_a = 1'b1; x_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      A = 16'(i);
      tick();
    end
    chk("wrap_cnt0", 32'(xfer_cnt), 32'd0);
    chk("wrap_X255", 32'(X),        32'd255);
    A = 16'h1234;
    tick();
    chk("wrap_cnt1", 32'(xfer_cnt), 32'd1);
    chk("wrap_X",    32'(X),        32'h1234);
    req_a = 1'b0; x_ready = 1'b0;
    tick();
    chk("full_hold_X",     32'(X),       32'h1234);
    chk("full_hold_valid", 32'(x_valid), 32'd1);

    // 6. async reset while FULL, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(x_valid),  32'd0);
    chk("async_X",     32'(X),        32'd0);
    chk("async_cnt",   32'(xfer_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1; A = 16'h0A0A; B = 16'h0B0B; x_ready = 1'b1;
    #1;
    chk("post_rst_ack_a", 32'(ack_a), 32'd1);
    chk("post_rst_ack_b", 32'(ack_b), 32'd0);
    chk("post_rst_sel",   32'(sel),   32'd0);
    tick();
    chk("post_rst_X", 32'(X), 32'h0A0A);
    #1;
    chk("post_rst_alt_ack_b", 32'(ack_b), 32'd1);
    tick();
    chk("post_rst_alt_X", 32'(X), 32'h0B0B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
